// File: rtl/z_result_buffer.sv
// z_result_buffer: in-order result FIFO between the ALU and the bus-side
// consumer. It holds {ZHigh, ZLow} pairs, and the oldest entry is shown on ZLow/ZHigh.
// Ports:
//   clock, clear (async active-low), flush (sync discard)
//   in_valid/in_ready/in_lo/in_hi : producer side (ALU)
//   out_valid/out_ready/ZLow/ZHigh : consumer side (bus)
//   count : number of stored entries, 0..DEPTH
module z_result_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                       clock,
  input  logic                       clear,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_WIDTH-1:0]      in_lo,
  input  logic [DATA_WIDTH-1:0]      in_hi,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      ZLow,
  output logic [DATA_WIDTH-1:0]      ZHigh,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] lo_q [DEPTH];
  logic [DATA_WIDTH-1:0] hi_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic push;
  logic pop;
  logic we;

  // Ready depends only on occupancy, so a full buffer
  // never accepts in the same cycle that it pops.
  assign in_ready  = (cnt_q != FULL);
  assign out_valid = (cnt_q != '0);
  assign count     = cnt_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Data is hidden while empty. A stale slot must never
  // reach the bus.
  assign ZLow  = out_valid ? lo_q[rd_ptr_q] : '0;
  assign ZHigh = out_valid ? hi_q[rd_ptr_q] : '0;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    we       = 1'b0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      we = push;
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        lo_q[i] <= '0;
        hi_q[i] <= '0;
      end
    end else if (we) begin
      lo_q[wr_ptr_q] <= in_lo;
      hi_q[wr_ptr_q] <= in_hi;
    end
  end

endmodule
